// File: rtl/row_sched_pkg.sv
// Shared constants and state encoding for the row scheduler and the
// neighbouring VGA timing / render blocks.
package row_sched_pkg;

  localparam int unsigned H_VIEW_DEF = 640;
  localparam int unsigned V_VIEW_DEF = 480;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned ROW_W  = 9;
  localparam int unsigned SIZE_W = 11;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StFull = 2'd2
  } sched_state_e;

  // Row to trace for the line after vpos; wraps to 0 at the visible line count.
  function automatic logic [ROW_W-1:0] next_row(input logic [POS_W-1:0] vpos,
                                                input int unsigned  v_view);
    logic [POS_W-1:0] nxt;
    nxt = vpos + POS_W'(1);
    if ({22'd0, nxt} >= v_view) begin
      return '0;
    end
    return nxt[ROW_W-1:0];
  endfunction

endpackage

// File: rtl/line_edge.sv
// Swap detector: one-cycle pulse on the first cycle hpos reaches H_VIEW.
module line_edge
  import row_sched_pkg::*;
#(
  parameter int unsigned H_VIEW = H_VIEW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [POS_W-1:0] hpos,
  output logic             swap
);

  logic at_view;
  logic was_view_q;

  assign at_view = (hpos == POS_W'(H_VIEW));

  // History resets to "was at H_VIEW" so a line already parked there does not swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      was_view_q <= 1'b1;
    end else begin
      was_view_q <= at_view;
    end
  end

  assign swap = at_view && !was_view_q;

endmodule

// File: rtl/row_sched.sv
// Per-line trace scheduler: requests the next row from the tracer and
// double-buffers its result so the renderer sees it from the next line swap.
module row_sched
  import row_sched_pkg::*;
#(
  parameter int unsigned H_VIEW = H_VIEW_DEF,
  parameter int unsigned V_VIEW = V_VIEW_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [POS_W-1:0]  hpos,
  input  logic [POS_W-1:0]  vpos,
  output logic              trace_req,
  output logic [ROW_W-1:0]  trace_row,
  input  logic              trace_valid,
  input  logic              trace_side,
  input  logic [SIZE_W-1:0] trace_size,
  output logic              trace_ready,
  output logic              row_side,
  output logic [SIZE_W-1:0] row_size,
  output logic              row_active,
  output logic [CNT_W-1:0]  underrun_count
);

  sched_state_e      state_q, state_d;
  logic              started_q;
  logic              swap;
  logic              capture;

  logic              pend_side_q, pend_side_d;
  logic [SIZE_W-1:0] pend_size_q, pend_size_d;
  logic              row_side_q, row_side_d;
  logic [SIZE_W-1:0] row_size_q, row_size_d;
  logic              row_active_q, row_active_d;
  logic [CNT_W-1:0]  under_q, under_d;
  logic [ROW_W-1:0]  row_q, row_d;

  line_edge #(
    .H_VIEW (H_VIEW)
  ) u_line_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .hpos    (hpos),
    .swap    (swap)
  );

  // started_q keeps trace_req low while reset is held; the first REQ follows release.
  assign trace_req   = (state_q == StReq) && started_q;
  assign trace_ready = (state_q == StWait) && !swap;
  assign capture     = trace_valid && trace_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq:   if (started_q) state_d = StWait;
      StWait:  if (capture) state_d = StFull;
      StFull:  state_d = StFull;
      default: state_d = StReq;
    endcase
    if (swap) begin
      state_d = StReq;
    end
  end

  always_comb begin
    pend_side_d  = pend_side_q;
    pend_size_d  = pend_size_q;
    row_side_d   = row_side_q;
    row_size_d   = row_size_q;
    row_active_d = row_active_q;
    under_d      = under_q;
    row_d        = row_q;

    if (capture) begin
      pend_side_d = trace_side;
      pend_size_d = trace_size;
    end

    if (swap) begin
      row_d = next_row(vpos, V_VIEW);
      if (state_q == StFull) begin
        row_side_d   = pend_side_q;
        row_size_d   = pend_size_q;
        row_active_d = 1'b1;
      end else begin
        row_side_d   = 1'b0;
        row_size_d   = '0;
        row_active_d = 1'b0;
        if (under_q != '1) begin
          under_d = under_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StReq;
      started_q    <= 1'b0;
      pend_side_q  <= 1'b0;
      pend_size_q  <= '0;
      row_side_q   <= 1'b0;
      row_size_q   <= '0;
      row_active_q <= 1'b0;
      under_q      <= '0;
      row_q        <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= 1'b1;
      pend_side_q  <= pend_side_d;
      pend_size_q  <= pend_size_d;
      row_side_q   <= row_side_d;
      row_size_q   <= row_size_d;
      row_active_q <= row_active_d;
      under_q      <= under_d;
      row_q        <= row_d;
    end
  end

  assign trace_row      = row_q;
  assign row_side       = row_side_q;
  assign row_size       = row_size_q;
  assign row_active     = row_active_q;
  assign underrun_count = under_q;

endmodule

// File: tb/tb_row_sched.sv
// Scoreboard bench for row_sched: each line pushes its expected post-swap
// state, which is popped and compared at the start of the following line.
module tb_row_sched;

  localparam int H = 640;
  localparam int V = 480;

  typedef struct packed {
    logic        act;
    logic        side;
    logic [10:0] size;
    logic [7:0]  under;
    logic [8:0]  row;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic        trace_req;
  logic [8:0]  trace_row;
  logic        trace_valid = 1'b0;
  logic        trace_side = 1'b0;
  logic [10:0] trace_size = '0;
  logic        trace_ready;
  logic        row_side;
  logic [10:0] row_size;
  logic        row_active;
  logic [7:0]  underrun_count;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_under = 0;
  int   exp_req = 0;
  int   req_cnt = 0;
  bit   req_expected = 1'b0;

  row_sched dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hpos           (hpos),
    .vpos           (vpos),
    .trace_req      (trace_req),
    .trace_row      (trace_row),
    .trace_valid    (trace_valid),
    .trace_side     (trace_side),
    .trace_size     (trace_size),
    .trace_ready    (trace_ready),
    .row_side       (row_side),
    .row_size       (row_size),
    .row_active     (row_active),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && trace_req) req_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("row_active", 32'(row_active), 32'(e.act));
    check("row_side", 32'(row_side), 32'(e.side));
    check("row_size", 32'(row_size), 32'(e.size));
    check("underrun", 32'(underrun_count), 32'(e.under));
    check("trace_row", 32'(trace_row), 32'(e.row));
  endtask

  // mode: 0 silent, 1 one-cycle answer at cycle d, 2 answer on swap cycle,
  // 3 valid held high all line (value changes after capture).
  task automatic run_line(input int v, input int mode, input int d, input logic s,
                          input logic [10:0] sz, input int hold, input int len);
    exp_t e;
    bit   took;
    int   nr;
    took = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      hpos        = 10'd0;
      vpos        = 10'(v);
      trace_side  = s;
      trace_size  = took ? sz + 11'd7 : sz;
      trace_valid = (mode == 1 && c == d) || (mode == 3);
      #1;
      if (c == 0) begin
        check_out();
        check("req_c0", 32'(trace_req), 32'(req_expected));
      end
      if (c == 1) check("req_c1", 32'(trace_req), 32'd0);
      if (mode == 1 && c == d) check("ready_wait", 32'(trace_ready), 32'd1);
      if (trace_valid && trace_ready) took = 1'b1;
    end
    @(negedge clk);
    hpos        = 10'(H);
    trace_valid = (mode == 2) || (mode == 3);
    trace_size  = sz + 11'd7;
    #1;
    check("ready_swap", 32'(trace_ready), 32'd0);
    nr = (v + 1 >= V) ? 0 : v + 1;
    if (mode == 1 || mode == 3) begin
      e.act = 1'b1; e.side = s; e.size = sz;
    end else begin
      e.act = 1'b0; e.side = 1'b0; e.size = '0;
      if (exp_under < 255) exp_under++;
    end
    e.under = 8'(exp_under);
    e.row   = 9'(nr);
    sb_q.push_back(e);
    exp_req++;
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      trace_valid = 1'b0;
    end
    trace_valid  = 1'b0;
    req_expected = (hold == 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req", 32'(trace_req), 32'd0);
    check("rst_row", 32'(trace_row), 32'd0);
    check("rst_active", 32'(row_active), 32'd0);
    check("rst_size", 32'(row_size), 32'd0);
    check("rst_under", 32'(underrun_count), 32'd0);
    reset_n      = 1'b1;
    exp_req++;
    req_expected = 1'b1;

    run_line(10, 1, 5, 1'b1, 11'd100, 1, 8);
    run_line(100, 0, 0, 1'b0, 11'd0, 1, 8);
    run_line(200, 2, 0, 1'b1, 11'd321, 1, 8);
    run_line(479, 1, 3, 1'b0, 11'd2047, 1, 8);
    run_line(0, 3, 0, 1'b1, 11'd555, 1, 8);
    run_line(5, 0, 0, 1'b0, 11'd0, 3, 8);
    run_line(6, 1, 2, 1'b1, 11'd42, 1, 8);

    // Reset while the tracer request is outstanding.
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'd7;
    #1;
    check_out();
    @(negedge clk);
    @(negedge clk);
    #2;
    check("wait_ready", 32'(trace_ready), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(trace_req), 32'd0);
    check("mid_rst_ready", 32'(trace_ready), 32'd0);
    check("mid_rst_active", 32'(row_active), 32'd0);
    check("mid_rst_under", 32'(underrun_count), 32'd0);
    check("mid_rst_row", 32'(trace_row), 32'd0);
    @(negedge clk);
    trace_valid  = 1'b1;
    trace_side   = 1'b1;
    trace_size   = 11'd999;
    reset_n      = 1'b1;
    exp_under    = 0;
    exp_req++;
    req_expected = 1'b1;
    run_line(30, 0, 0, 1'b0, 11'd0, 1, 8);

    for (int i = 0; i < 300; i++) begin
      run_line(i % V, 0, 0, 1'b0, 11'd0, 1, 2);
    end
    @(negedge clk);
    hpos = 10'd0;
    #1;
    check_out();
    check("req_count", 32'(req_cnt), 32'(exp_req));
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
